// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive pair: parity modes,
// transmitter state encoding and the parity helper.
package uart_pkg;

  localparam int unsigned PAR_NONE      = 0;
  localparam int unsigned PAR_ODD       = 1;
  localparam int unsigned PAR_EVEN      = 2;
  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } tx_state_t;

  // Callers zero-extend narrower payloads, which leaves the XOR unchanged.
  function automatic logic f_parity(input logic [MAX_DATA_BITS-1:0] data,
                                    input int unsigned              mode);
    if (mode == PAR_ODD)
      return ~(^data);
    else if (mode == PAR_EVEN)
      return ^data;
    else
      return 1'b0;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/full/empty; shared by the UART
// transmitter and receiver.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_count_nxt;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + 1'b1;
    else if (w_pop && !w_push)
      w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// Oversampled UART transmitter fed by a transmit FIFO; frames are sent
// back-to-back while the FIFO holds data.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          baud_en,
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = 4;

  tx_state_t              r_state;
  tx_state_t              w_next;
  logic [TICK_W-1:0]      r_tick;
  logic [BIT_W-1:0]       r_bit;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par;
  logic                   r_tx;
  logic                   r_busy;

  logic                   w_tx;
  logic                   w_busy;
  logic                   w_pop;
  logic                   w_bit_end;
  logic                   w_last_data;
  logic                   w_last_stop;
  logic [DATA_BITS-1:0]   w_fifo_dout;
  logic                   w_full;
  logic                   w_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (din_valid),
    .i_pop   (w_pop),
    .i_din   (din),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  assign w_bit_end   = baud_en && (r_tick == TICK_W'(OVERSAMPLE - 1));
  assign w_last_data = (r_bit == BIT_W'(DATA_BITS - 1));
  assign w_last_stop = (r_bit == BIT_W'(STOP_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_START;
      S_START: if (w_bit_end) w_next = S_DATA;
      S_DATA:  if (w_bit_end && w_last_data)
                 w_next = (PARITY != PAR_NONE) ? S_PAR : S_STOP;
      S_PAR:   if (w_bit_end) w_next = S_STOP;
      S_STOP:  if (w_bit_end && w_last_stop)
                 w_next = w_empty ? S_IDLE : S_START;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_tx   = 1'b1;
    w_busy = 1'b1;
    w_pop  = 1'b0;
    unique case (r_state)
      S_IDLE:  begin
                 w_busy = 1'b0;
                 w_pop  = !w_empty;
               end
      S_START: w_tx = 1'b0;
      S_DATA:  w_tx = r_shift[0];
      S_PAR:   w_tx = r_par;
      S_STOP:  w_pop = w_bit_end && w_last_stop && !w_empty;
      default: w_busy = 1'b0;
    endcase
  end

  // tx/busy are registered from the state, so the line lags the FSM by one
  // edge; bit lengths are unaffected because every state lasts a full bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_tx   <= w_tx;
      r_busy <= w_busy;
      if (w_pop) begin
        r_tick  <= '0;
        r_bit   <= '0;
        r_shift <= w_fifo_dout;
        r_par   <= f_parity(MAX_DATA_BITS'(w_fifo_dout), PARITY);
      end else if (w_bit_end && r_state != S_IDLE) begin
        r_tick <= '0;
        r_bit  <= (w_next != r_state) ? '0 : r_bit + 1'b1;
        if (r_state == S_DATA) r_shift <= r_shift >> 1;
      end else if (baud_en && r_state != S_IDLE) begin
        r_tick <= r_tick + 1'b1;
      end
    end
  end

  assign din_ready = !w_full;
  assign tx        = r_tx;
  assign busy      = r_busy;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO. It is the next generation of our 16x-oversampled serial transmitter for the USB loopback path: configurable data width, parity, stop bits and oversampling, a clock-enable baud tick, and a valid/ready input handshake. Back-to-back frames are sent without idle gaps while the FIFO holds data. It sits between the loopback datapath and the FPGA TX pin.

## Interface
- DATA_BITS, 8, payload bits per frame (5..9)
- OVERSAMPLE, 16, baud_en ticks per bit (≥2)
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame (1 or 2)
- FIFO_DEPTH, 4, FIFO entries (power of two, ≥2)
- clk  input  1  system clock; single clock domain
- rst_n  input  1  reset; synchronous and active-low
- baud_en  input  1  one-cycle oversample tick; tie high to make each bit OVERSAMPLE clk cycles
- din  input  DATA_BITS  word to send; sent LSB first
- din_valid  input  1  din holds a word to enqueue
- din_ready  output  1  FIFO not full; a word is accepted on a clk edge with din_valid && din_ready
- tx  output  1  serial line; idles high
- busy  output  1  a frame is on the line
- fifo_count  output  $clog2(FIFO_DEPTH)+1  words held in the FIFO

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- IDLE:
  - tx = 1.
  - If FIFO non-empty: pop the word into the shift register, clear the tick and bit counters, go to START.
- Bit timing:
  - The tick counter increments on baud_en.
  - A bit ends on the baud_en cycle where the counter equals OVERSAMPLE-1. The counter then wraps to 0.
- START: tx = 0 for one bit, then go to DATA.
- DATA:
  - tx = shift register bit 0. The register shifts right at each bit end.
  - After DATA_BITS bits: go to PAR if PARITY≠0, else STOP.
- PAR:
  - Even parity: tx = XOR of the payload bits.
  - Odd parity: tx = the inverse of that XOR.
  - Parity is computed from the word at pop time. One bit long.
- STOP: tx = 1 for STOP_BITS bits. At the end of the last stop bit:
  - FIFO non-empty: pop and go straight to START. No idle cycle.
  - Otherwise: go to IDLE.
- busy = 1 in START, DATA, PAR and STOP; 0 in IDLE.
- din_ready and fifo_count are registered from FIFO occupancy. din_ready never depends combinationally on din_valid.

## Timing
- Reset values (rst_n low at a clk edge):
  - tx = 1, busy = 0, din_ready = 1, fifo_count = 0.
  - State = IDLE, FIFO emptied, counters cleared.
- Reset mid-frame aborts the frame. tx = 1 on the next edge. No partial frame resumes.
- Latency from accept to first start-bit cycle, FIFO empty and IDLE:
  - Accept at edge N.
  - Pop at edge N+1.
  - tx = 0 from edge N+2.
- Frame length with baud_en = 1: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × OVERSAMPLE cycles.
- Push and pop in the same cycle:
  - Occupancy is unchanged.
  - When full, the push is refused because din_ready = 0. The pop frees a slot, and din_ready = 1 from the next edge.
  - When empty, the push is stored and popped on the following edge.
- baud_en low freezes the tick counter and holds tx. The state and FIFO still accept pushes.
- FIFO pointers wrap modulo FIFO_DEPTH. Word order is strictly preserved.

## Structure
- Shared package uart_pkg holds:
  - Parity encodings PAR_NONE, PAR_ODD, PAR_EVEN.
  - The state encoding.
  - A parity function over a DATA_BITS vector.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Single-clock, registered count, push/pop/full/empty.
  - Reusable by the companion receiver.
- The top level holds the FSM, tick counter, bit counter, shift register and parity bit.

## Test plan
- Defaults, baud_en = 1, send 0x55:
  - tx is low for 16 cycles.
  - Then bits 1,0,1,0,1,0,1,0, each 16 cycles, LSB first.
  - Then high for 16. busy lasts exactly 160 cycles.
- PARITY = 2, DATA_BITS = 7, STOP_BITS = 2, send 0x13: frame is start, 1,1,0,0,1,0,0, parity 1, stop, stop. Total 11 × 16 cycles.
- Push 5 words with FIFO_DEPTH = 4 while busy:
  - din_ready drops after the 4th accepted word.
  - The 5th word is accepted one edge after the first pop.
  - All 5 go out back-to-back, and tx never idles between stop and start.
- baud_en pulsing every 3rd cycle, OVERSAMPLE = 4, send 0xA0: each bit lasts 12 cycles. tx is stable between ticks.
- Assert rst_n low during DATA bit 3 with 2 words queued:
  - Next edge: tx = 1, busy = 0, fifo_count = 0.
  - No further frame is sent.
- Same-cycle push while the FIFO is empty and IDLE: the word appears as a start bit exactly 2 edges after acceptance.
